// File: rtl/rf_read_stage.sv
// rf_read_stage: register-file read side for the decode stage.
//   NUM_REGS x DATA_W architectural registers (R0 hardwired to zero), one
//   write port from writeback, two independent registered read ports with a
//   1-cycle latency, obeying stall/flush. Priority: reset > flush > stall > capture.
//
// Optional feature macro: RF_BYPASS_EN
//   Defined   : a same-cycle write to the address being read is forwarded (new value).
//   Undefined : the read sees the array content before the write (old value).
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_stall, i_flush        pipeline hold / bubble for the read outputs
//   i_re1, i_rd_addr1       read port 1 enable / address
//   i_re2, i_rd_addr2       read port 2 enable / address
//   i_we, i_wr_addr, i_wr_data  writeback port (ignores stall/flush)
//   o_rd_data1, o_rd_data2  registered read data
//   o_rd_valid              1 = at least one port captured on the last edge

// Per-port output register: flush clears, stall holds, enable captures.
module rf_read_port #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_re,
  input  logic [DATA_W-1:0] i_src,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_rd_data <= '0;
    else if (i_flush)           r_rd_data <= '0;
    else if (!i_stall && i_re)  r_rd_data <= i_src;
  end

  assign o_rd_data = r_rd_data;
endmodule

module rf_read_stage #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic              o_rd_valid
);
  localparam int                NUM_RD   = 2;
  localparam logic [ADDR_W:0]   LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  // R0 is not stored at all: entries 1..NUM_REGS-1 only.
  logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
  logic              r_rd_valid;

  logic                           w_wr_ok;
  logic [NUM_RD-1:0]              w_re;
  logic [NUM_RD-1:0][ADDR_W-1:0]  w_rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  w_rd_data;

  assign w_wr_ok   = i_we && (i_wr_addr != '0) && ({1'b0, i_wr_addr} < LP_NREGS);
  assign w_re      = {i_re2, i_re1};
  assign w_rd_addr = {i_rd_addr2, i_rd_addr1};

  // Write port: independent of stall/flush.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                                   r_regs[g] <= '0;
      else if (w_wr_ok && i_wr_addr == ADDR_W'(g))    r_regs[g] <= i_wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [DATA_W-1:0] w_arr;
    logic [DATA_W-1:0] w_src;

    // Address 0 and addresses >= NUM_REGS match no entry and read as zero.
    always_comb begin
      w_arr = '0;
      for (int i = 1; i < NUM_REGS; i++)
        if (w_rd_addr[p] == ADDR_W'(i)) w_arr = r_regs[i];
    end

`ifdef RF_BYPASS_EN
    // w_wr_ok already excludes R0 and out-of-range, so forwarding never leaks.
    assign w_src = (w_wr_ok && i_wr_addr == w_rd_addr[p]) ? i_wr_data : w_arr;
`else
    assign w_src = w_arr;
`endif

    rf_read_port #(.DATA_W(DATA_W)) u_port (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_stall   (i_stall),
      .i_flush   (i_flush),
      .i_re      (w_re[p]),
      .i_src     (w_src),
      .o_rd_data (w_rd_data[p])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_rd_valid <= 1'b0;
    else if (i_flush)  r_rd_valid <= 1'b0;
    else if (!i_stall) r_rd_valid <= |w_re;
  end

  assign o_rd_data1 = w_rd_data[0];
  assign o_rd_data2 = w_rd_data[1];
  assign o_rd_valid = r_rd_valid;
endmodule

// File: tb/tb_rf_read_stage.sv
module tb_rf_read_stage;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, flush, re1, re2, we;
  logic [3:0]  a1, a2, wa;
  logic [15:0] wd;
  logic [15:0] d1, d2;
  logic        vld;

  typedef struct {
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ev;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rel_pending = 1'b0;

  always #5 clk = ~clk;

  rf_read_stage #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_stall    (stall),
    .i_flush    (flush),
    .i_re1      (re1),
    .i_rd_addr1 (a1),
    .i_re2      (re2),
    .i_rd_addr2 (a2),
    .i_we       (we),
    .i_wr_addr  (wa),
    .i_wr_data  (wd),
    .o_rd_data1 (d1),
    .o_rd_data2 (d2),
    .o_rd_valid (vld)
  );

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0; re1 = 0; re2 = 0; we = 0;
    a1 = 0; a2 = 0; wa = 0; wd = 0;
  endtask

  // Drive one cycle of stimulus on the falling edge and queue what the
  // outputs must look like after the following rising edge.
  task automatic vec(input logic st, input logic fl,
                     input logic r1, input logic [3:0] ad1,
                     input logic r2, input logic [3:0] ad2,
                     input logic w, input logic [3:0] wad, input logic [15:0] wdat,
                     input logic [15:0] e1, input logic [15:0] e2, input logic ev,
                     input int id);
    exp_t e;
    @(negedge clk);
    if (rel_pending) begin
      rst_n = 1'b1;
      rel_pending = 1'b0;
    end
    stall = st; flush = fl; re1 = r1; a1 = ad1; re2 = r2; a2 = ad2;
    we = w; wa = wad; wd = wdat;
    e.e1 = e1; e.e2 = e2; e.ev = ev; e.id = id;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: outputs settle just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data1", e.id, d1, e.e1);
        chk("rd_data2", e.id, d2, e.e2);
        chk("rd_valid", e.id, {15'd0, vld}, {15'd0, e.ev});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p7, b6;
    p7 = BYP ? 16'h1234 : 16'h0001;
    b6 = BYP ? 16'h6666 : 16'h0000;
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("reset d1", 0, d1, 16'h0);
    chk("reset d2", 0, d2, 16'h0);
    chk("reset vld", 0, {15'd0, vld}, 16'h0);
    rel_pending = 1'b1;
    //   st fl r1 a1  r2 a2  we wa  wd        e1        e2        ev id
    vec(0, 0, 1, 5,  0, 0,  0, 0,  16'h0,    16'h0,    16'h0,    1, 1);
    vec(0, 0, 0, 0,  0, 0,  1, 3,  16'hBEEF, 16'h0,    16'h0,    0, 2);
    vec(0, 0, 1, 3,  1, 3,  0, 0,  16'h0,    16'hBEEF, 16'hBEEF, 1, 3);
    vec(0, 0, 0, 0,  0, 0,  1, 7,  16'h0001, 16'hBEEF, 16'hBEEF, 0, 4);
    vec(0, 0, 1, 7,  0, 0,  1, 7,  16'h1234, p7,       16'hBEEF, 1, 5);
    vec(0, 0, 0, 0,  1, 7,  0, 0,  16'h0,    p7,       16'h1234, 1, 6);
    vec(0, 0, 1, 0,  0, 0,  1, 0,  16'hFFFF, 16'h0,    16'h1234, 1, 7);
    vec(0, 0, 1, 0,  0, 0,  0, 0,  16'h0,    16'h0,    16'h1234, 1, 8);
    vec(0, 0, 0, 0,  1, 12, 1, 12, 16'hAAAA, 16'h0,    16'h0,    1, 9);
    vec(0, 0, 1, 4,  1, 12, 0, 0,  16'h0,    16'h0,    16'h0,    1, 10);
    vec(0, 0, 1, 3,  0, 0,  0, 0,  16'h0,    16'hBEEF, 16'h0,    1, 11);
    vec(1, 0, 1, 7,  1, 7,  0, 0,  16'h0,    16'hBEEF, 16'h0,    1, 12);
    vec(1, 0, 1, 5,  1, 3,  1, 5,  16'h5555, 16'hBEEF, 16'h0,    1, 13);
    vec(1, 0, 1, 1,  0, 0,  0, 0,  16'h0,    16'hBEEF, 16'h0,    1, 14);
    vec(0, 0, 1, 5,  0, 0,  0, 0,  16'h0,    16'h5555, 16'h0,    1, 15);
    vec(1, 1, 1, 3,  0, 0,  0, 0,  16'h0,    16'h0,    16'h0,    0, 16);
    vec(0, 0, 1, 7,  0, 0,  0, 0,  16'h0,    16'h1234, 16'h0,    1, 17);
    vec(0, 0, 0, 3,  0, 3,  0, 0,  16'h0,    16'h1234, 16'h0,    0, 18);
    vec(1, 0, 1, 3,  0, 0,  0, 0,  16'h0,    16'h1234, 16'h0,    0, 19);
    vec(0, 1, 0, 0,  1, 3,  0, 0,  16'h0,    16'h0,    16'h0,    0, 20);
    vec(0, 0, 1, 3,  1, 5,  0, 0,  16'h0,    16'hBEEF, 16'h5555, 1, 21);
    drain();

    // Asynchronous reset between edges: outputs clear without a clock.
    #1;
    rst_n = 1'b0;
    #1;
    chk("async d1", 21, d1, 16'h0);
    chk("async d2", 21, d2, 16'h0);
    chk("async vld", 21, {15'd0, vld}, 16'h0);
    @(negedge clk);
    idle();
    @(posedge clk);
    #2;
    chk("rst hold d2", 21, d2, 16'h0);
    rel_pending = 1'b1;
    vec(0, 0, 1, 3,  0, 0,  0, 0,  16'h0,    16'h0,    16'h0,    1, 22);
    vec(0, 0, 1, 6,  1, 6,  1, 6,  16'h6666, b6,       b6,       1, 23);
    vec(0, 0, 1, 6,  1, 6,  0, 0,  16'h0,    16'h6666, 16'h6666, 1, 24);
    vec(0, 0, 0, 0,  1, 5,  0, 0,  16'h0,    16'h6666, 16'h0,    1, 25);
    drain();
    @(negedge clk);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
